// File: rtl/weight_fifo_bank_if.sv
// Row-write / per-column-pop bus between the load path and the weight FIFO bank.
interface weight_fifo_bank_if #(
  parameter int fifo_width = 16,
  parameter int data_width = 8
);
  logic                             wr_en;
  logic [fifo_width*data_width-1:0] wr_data;
  logic [fifo_width-1:0]            fifo_en;
  logic [fifo_width*data_width-1:0] rd_data;
  logic [fifo_width-1:0]            rd_valid;
  logic [fifo_width-1:0]            col_empty;
  logic                             full;
  logic                             empty;
  logic                             overflow;
  logic                             underflow;

  modport master (
    output wr_en, wr_data, fifo_en,
    input  rd_data, rd_valid, col_empty, full, empty, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, fifo_en,
    output rd_data, rd_valid, col_empty, full, empty, overflow, underflow
  );
endinterface

// File: rtl/weight_fifo_bank.sv
// Bank of column FIFOs sharing one write pointer; each column pops independently
// under its fifo_en bit with registered read data.
module weight_fifo_bank #(
  parameter int fifo_width = 16,
  parameter int data_width = 8,
  parameter int depth      = 16
) (
  input logic               clk,
  input logic               reset,
  weight_fifo_bank_if.slave bus
);
  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [fifo_width*data_width-1:0] mem [depth];
  logic [PW-1:0]                    wr_ptr;
  logic [PW-1:0]                    rd_ptr [fifo_width];
  logic [CW-1:0]                    count  [fifo_width];
  logic [fifo_width-1:0]            pop_ok;
  logic [fifo_width-1:0]            col_full;
  logic [fifo_width-1:0]            col_empty;
  logic                             push_ok;
  logic [fifo_width*data_width-1:0] rd_data;
  logic [fifo_width-1:0]            rd_valid;
  logic                             overflow;
  logic                             underflow;

  // A full column that pops in the same cycle frees its slot, so a push is
  // still accepted and full-rate streaming needs no bubble.
  always_comb begin
    pop_ok    = '0;
    col_full  = '0;
    col_empty = '0;
    for (int unsigned i = 0; i < fifo_width; i++) begin
      pop_ok[i]    = bus.fifo_en[i] && (count[i] != '0);
      col_full[i]  = (count[i] == DEPTH_C);
      col_empty[i] = (count[i] == '0);
    end
    push_ok = bus.wr_en && ((col_full & ~pop_ok) == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_data   <= '0;
      rd_valid  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int unsigned i = 0; i < fifo_width; i++) begin
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (bus.wr_en && !push_ok)
        overflow <= 1'b1;
      if ((bus.fifo_en & ~pop_ok) != '0)
        underflow <= 1'b1;
      rd_valid <= pop_ok;
      for (int unsigned i = 0; i < fifo_width; i++) begin
        if (pop_ok[i]) begin
          rd_data[i*data_width +: data_width] <= mem[rd_ptr[i]][i*data_width +: data_width];
          rd_ptr[i] <= rd_ptr[i] + PW'(1);
        end
        if (push_ok && !pop_ok[i])
          count[i] <= count[i] + CW'(1);
        else if (!push_ok && pop_ok[i])
          count[i] <= count[i] - CW'(1);
      end
    end
  end

  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;
  assign bus.col_empty = col_empty;
  assign bus.full      = |col_full;
  assign bus.empty     = &col_empty;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule
